// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: streaming integer to IEEE-754 single-precision converter.
//
// Three register stages, all advancing together whenever the output register
// can accept new data (adv = out_ready || !out_valid):
//   stage 1: sign / magnitude split of the incoming integer
//   stage 2: leading-one detect and left-normalise
//   stage 3: exponent build, optional rounding, pack into float_out
//
// Parameters:
//   IN_WIDTH  input integer width, 2..32
//   SIGNED    1 = two's complement input, 0 = unsigned input
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   in_valid   int_in holds a sample
//   in_ready   block accepts the sample this cycle (combinational)
//   int_in     integer sample
//   out_valid  float_out holds a result
//   out_ready  downstream accepts the result this cycle
//   float_out  {sign, exp[7:0], frac[22:0]}
//
// Compile-time option:
//   INT_TO_FLOAT_RNE_EN  defined   -> round to nearest, ties to even
//                        undefined -> truncate toward zero
`timescale 1ns/1ps

module int_to_float_pipe #(
  parameter int unsigned IN_WIDTH = 16,
  parameter bit          SIGNED   = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] int_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         float_out
);

  localparam int unsigned P_W    = 5;   // leading-one index, 0..31
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned EXT_W  = 32;  // normalised value left-aligned to 32 bits
  localparam int unsigned EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;

  // Whole-pipeline advance: the output slot is free or being drained.
  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv && resetn;

  // ---------------------------------------------------------------------------
  // Stage 1: sign / magnitude
  // ---------------------------------------------------------------------------
  logic                s1_sign_d;
  logic [IN_WIDTH-1:0] s1_mag_d;

  // Negation in IN_WIDTH bits maps the most-negative value onto 2^(IN_WIDTH-1),
  // which is the correct unsigned magnitude.
  always_comb begin
    s1_sign_d = 1'b0;
    s1_mag_d  = int_in;
    if (SIGNED && int_in[IN_WIDTH-1]) begin
      s1_sign_d = 1'b1;
      s1_mag_d  = IN_WIDTH'(~int_in) + IN_WIDTH'(1);
    end
  end

  logic                s1_valid;
  logic                s1_sign;
  logic [IN_WIDTH-1:0] s1_mag;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= s1_sign_d;
      s1_mag   <= s1_mag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: leading-one detect and normalise
  // ---------------------------------------------------------------------------
  logic [P_W-1:0]      p_d;
  logic                s2_zero_d;
  logic [IN_WIDTH-1:0] s2_norm_d;

  // Ascending scan: the highest set bit is the last one to write p_d.
  always_comb begin
    p_d = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag[i]) begin
        p_d = P_W'(i);
      end
    end
    s2_zero_d = (s1_mag == '0);
    s2_norm_d = s1_mag << (P_W'(IN_WIDTH - 1) - p_d);
  end

  logic                s2_valid;
  logic                s2_sign;
  logic                s2_zero;
  logic [P_W-1:0]      s2_p;
  logic [IN_WIDTH-1:0] s2_norm;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_p     <= '0;
      s2_norm  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s2_zero_d;
      s2_p     <= p_d;
      s2_norm  <= s2_norm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round and pack
  // ---------------------------------------------------------------------------
  // Left-aligning to 32 bits puts the implicit one at bit 31, the fraction at
  // [30:8] and any dropped bits at [7:0]. For IN_WIDTH <= 24 the dropped bits
  // are constant zero, so rounding never changes the result.
  logic [EXT_W-1:0]  ext;
  logic [FRAC_W-1:0] frac_c;
  logic [EXP_W-1:0]  exp_c;
  logic [31:0]       packed_c;

  assign ext = EXT_W'(s2_norm) << (EXT_W - IN_WIDTH);

`ifdef INT_TO_FLOAT_RNE_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [FRAC_W:0] frac_inc;

  assign guard    = ext[7];
  assign sticky   = |ext[6:0];
  assign round_up = guard && (sticky || ext[8]);
  assign frac_inc = {1'b0, ext[30:8]} + (FRAC_W + 1)'(round_up);

  // A carry out of the fraction means the mantissa became 2.0: renormalise.
  always_comb begin
    exp_c  = EXP_BIAS + EXP_W'(s2_p);
    frac_c = frac_inc[FRAC_W-1:0];
    if (frac_inc[FRAC_W]) begin
      frac_c = '0;
      exp_c  = exp_c + EXP_W'(1);
    end
  end

  // The implicit leading one is never stored.
  logic unused_c;
  assign unused_c = ext[31];
`else
  always_comb begin
    exp_c  = EXP_BIAS + EXP_W'(s2_p);
    frac_c = ext[30:8];
  end

  // Implicit one and the truncated tail bits are intentionally discarded.
  logic unused_c;
  assign unused_c = ^{ext[31], ext[7:0]};
`endif

  // Zero always packs as +0.
  always_comb begin
    packed_c = {s2_sign, exp_c, frac_c};
    if (s2_zero) begin
      packed_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      float_out <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      float_out <= s2_valid ? packed_c : 32'h0;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Testbench for int_to_float_pipe: three instances (16-bit signed, 16-bit
// unsigned, 32-bit signed). Directed vector table with latency checks, a
// mid-stream reset sequence and randomised backpressure streams scored against
// an arithmetic reference model.
`timescale 1ns/1ps

module tb_int_to_float_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [31:0] fo   [3];
  logic [15:0] d0;
  logic [15:0] d1;
  logic [31:0] d2;

  int tests = 0;
  int fails = 0;

  int_to_float_pipe #(.IN_WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]), .int_in(d0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .float_out(fo[0]));

  int_to_float_pipe #(.IN_WIDTH(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]), .int_in(d1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .float_out(fo[1]));

  int_to_float_pipe #(.IN_WIDTH(32), .SIGNED(1'b1)) u_s32 (
    .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]), .int_in(d2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .float_out(fo[2]));

  function automatic int width_of(int sel);
    return (sel == 2) ? 32 : 16;
  endfunction

  function automatic bit signed_of(int sel);
    return (sel != 1);
  endfunction

  // Reference: exact value -> sign, binary exponent, 24-bit significand.
  function automatic logic [31:0] ref_float(logic [31:0] raw, int width, bit sgn);
    longint v, mag, q;
    int     p, sh;
    bit     neg;
    v = longint'(raw) & ((longint'(1) << width) - 1);
    if (sgn && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
    neg = (v < 0);
    mag = neg ? -v : v;
    if (mag == 0) return 32'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh = p - 23;
      q  = mag >> sh;
`ifdef INT_TO_FLOAT_RNE_EN
      begin
        longint rem, half;
        rem  = mag - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == (longint'(1) << 24)) begin
          q = q >> 1;
          p = p + 1;
        end
      end
`endif
    end
    return {neg, 8'(127 + p), 23'(q - (longint'(1) << 23))};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int sel, logic valid, logic [31:0] data);
    case (sel)
      0: begin iv[0] = valid; d0 = data[15:0]; end
      1: begin iv[1] = valid; d1 = data[15:0]; end
      default: begin iv[2] = valid; d2 = data; end
    endcase
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = 32'($urandom_range(0, 40)) - 32'd20;
      1: begin
        case ($urandom_range(0, 10))
          0: r = 32'h0;
          1: r = 32'h1;
          2: r = 32'hFFFFFFFF;
          3: r = 32'h80000000;
          4: r = 32'h7FFFFFFF;
          5: r = 32'h01000001;
          6: r = 32'h01000003;
          7: r = 32'h01FFFFFF;
          8: r = 32'h00FFFFFF;
          9: r = 32'h00008000;
          default: r = 32'h0000FFFF;
        endcase
      end
      2: r = $urandom >> $urandom_range(0, 31);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Called just after the acceptance edge; result must appear on the third edge.
  task automatic expect_out(int sel, logic [31:0] expv, string name);
    int lat = 1;
    while (!ov[sel] && lat < 8) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_value"}, fo[sel], expv);
  endtask

  task automatic run_stream(int sel, int n, string name);
    logic [31:0] q[$];
    logic [31:0] cur, held, expv;
    int  sent = 0;
    int  cyc  = 0;
    bit  have = 0;
    bit  stalled = 0;
    bit  accept, deliver;
    cur  = '0;
    held = '0;
    while ((sent < n || q.size() != 0) && cyc < 40 * n + 100) begin
      if (stalled) begin
        check({name, "_hold_valid"}, 32'(ov[sel]), 32'd1);
        check({name, "_hold_data"}, fo[sel], held);
      end
      ordy[sel] = ($urandom_range(0, 9) < 6);
      if (!have && sent < n) begin
        cur  = rand_val();
        have = 1;
      end
      set_in(sel, have, cur);
      #1;
      check({name, "_in_ready"}, 32'(ir[sel]), 32'(!(ov[sel] && !ordy[sel])));
      accept  = iv[sel] && ir[sel];
      deliver = ov[sel] && ordy[sel];
      stalled = ov[sel] && !ordy[sel];
      held    = fo[sel];
      if (deliver) begin
        check({name, "_spurious"}, 32'(q.size() == 0), 32'd0);
        if (q.size() != 0) begin
          expv = q.pop_front();
          check({name, "_data"}, fo[sel], expv);
        end
      end
      if (accept) begin
        q.push_back(ref_float(cur, width_of(sel), signed_of(sel)));
        sent++;
        have = 0;
      end
      tick();
      cyc++;
    end
    set_in(sel, 1'b0, 32'h0);
    ordy[sel] = 1'b1;
    check({name, "_sent"}, 32'(sent), 32'(n));
    check({name, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rst_vals[3];

    vecs.push_back('{0, 32'h00000001, 32'h3F800000, "s16_one"});
    vecs.push_back('{0, 32'h0000FFFF, 32'hBF800000, "s16_minus_one"});
    vecs.push_back('{0, 32'h00008000, 32'hC7000000, "s16_most_neg"});
    vecs.push_back('{0, 32'h00000000, 32'h00000000, "s16_zero"});
    vecs.push_back('{0, 32'h00007FFF, 32'h46FFFE00, "s16_max"});
    vecs.push_back('{1, 32'h0000FFFF, 32'h477FFF00, "u16_max"});
    vecs.push_back('{1, 32'h00008000, 32'h47000000, "u16_msb"});
    vecs.push_back('{1, 32'h00000000, 32'h00000000, "u16_zero"});
    vecs.push_back('{2, 32'hFFFFFFFF, 32'hBF800000, "s32_minus_one"});
    vecs.push_back('{2, 32'h80000000, 32'hCF000000, "s32_most_neg"});
    vecs.push_back('{2, 32'h00FFFFFF, 32'h4B7FFFFF, "s32_24bit_exact"});
`ifdef INT_TO_FLOAT_RNE_EN
    vecs.push_back('{2, 32'd16777217, 32'h4B800000, "s32_tie_down"});
    vecs.push_back('{2, 32'd16777219, 32'h4B800002, "s32_tie_up"});
    vecs.push_back('{2, 32'd33554431, 32'h4C000000, "s32_exp_carry"});
    vecs.push_back('{2, 32'hFEFFFFFD, 32'hCB800002, "s32_neg_tie_up"});
    vecs.push_back('{2, 32'h7FFFFFFF, 32'h4F000000, "s32_max"});
`else
    vecs.push_back('{2, 32'd16777217, 32'h4B800000, "s32_trunc_a"});
    vecs.push_back('{2, 32'd16777219, 32'h4B800001, "s32_trunc_b"});
    vecs.push_back('{2, 32'd33554431, 32'h4BFFFFFF, "s32_trunc_c"});
    vecs.push_back('{2, 32'hFEFFFFFD, 32'hCB800001, "s32_neg_trunc"});
    vecs.push_back('{2, 32'h7FFFFFFF, 32'h4EFFFFFF, "s32_max"});
`endif

    resetn = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 32'h0);
      ordy[s] = 1'b1;
    end
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_out_valid_%0d", s), 32'(ov[s]), 32'd0);
      check($sformatf("reset_float_out_%0d", s), fo[s], 32'h0);
      check($sformatf("reset_in_ready_%0d", s), 32'(ir[s]), 32'd0);
    end
    resetn = 1'b1;

    // Directed table, one sample at a time with out_ready high.
    foreach (vecs[i]) begin
      set_in(vecs[i].sel, 1'b1, vecs[i].din);
      #1;
      check({vecs[i].name, "_in_ready"}, 32'(ir[vecs[i].sel]), 32'd1);
      tick();
      set_in(vecs[i].sel, 1'b0, 32'h0);
      expect_out(vecs[i].sel, vecs[i].exp, vecs[i].name);
    end
    tick();

    // Mid-stream reset with three samples in flight on the 32-bit instance.
    rst_vals[0] = 32'd5;
    rst_vals[1] = 32'hFFFFFF00;
    rst_vals[2] = 32'd123456789;
    ordy[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(2, 1'b1, rst_vals[k]);
      #1;
      check("rst_fill_in_ready", 32'(ir[2]), 32'd1);
      tick();
    end
    set_in(2, 1'b0, 32'h0);
    ordy[2] = 1'b0;
    resetn  = 1'b0;
    #1;
    check("rst_in_ready_low", 32'(ir[2]), 32'd0);
    tick();
    check("rst_out_valid", 32'(ov[2]), 32'd0);
    check("rst_float_out", fo[2], 32'h0);
    resetn  = 1'b1;
    ordy[2] = 1'b1;
    set_in(2, 1'b1, 32'd1000);
    #1;
    check("rst_first_accept", 32'(ir[2]), 32'd1);
    tick();
    set_in(2, 1'b0, 32'h0);
    expect_out(2, 32'h447A0000, "rst_new_sample");
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_no_stale_output", 32'(ov[2]), 32'd0);
    end

    // Randomised backpressure streams.
    run_stream(0, 10, "bp10_s16");
    run_stream(2, 300, "rand_s32");
    run_stream(1, 100, "rand_u16");
    run_stream(0, 100, "rand_s16");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_to_float_pipe.md
# int_to_float_pipe

- Streaming integer-to-IEEE-754 single-precision converter.
- Parametrised input width and signedness; 3-stage pipeline with valid/ready handshake on both sides.
- Rounding mode is selectable at compile time.
- Sits between the sensor-frame integer datapath and the float processing/output stage. Sustains one conversion per clock under backpressure.

## Interface
Parameters:
- IN_WIDTH, 16, input integer width; legal range 2..32.
- SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned.

Ports:
- clk  input  1  system clock; one clock domain; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  int_in holds a sample.
- in_ready  output  1  block accepts the sample this cycle.
- int_in  input  IN_WIDTH  integer sample.
- out_valid  output  1  float_out holds a result.
- out_ready  input  1  downstream accepts the result this cycle.
- float_out  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.

## Operation
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1, sign/magnitude:
  - sign = int_in[IN_WIDTH-1] if SIGNED, else 0.
  - mag = |int_in|, IN_WIDTH bits unsigned.
  - Most-negative input (-2^(IN_WIDTH-1)) gives mag = 2^(IN_WIDTH-1) exactly; no overflow.
- Stage 2, normalise:
  - p = index of the leading one of mag (0..IN_WIDTH-1).
  - Left-shift mag so the leading one lands at bit IN_WIDTH-1.
  - Carry a zero flag when mag == 0.
- Stage 3, round and pack:
  - exp = 127 + p.
  - frac = the 23 bits below the leading one.
  - When p > 23, the dropped bits produce guard and sticky bits; rounding per Configuration.
  - If the rounding increment overflows frac, set frac = 0 and exp = exp + 1.
  - Zero input gives float_out = 0x00000000 (+0, never -0).
- Exactness: inputs with at most 24 significant bits are exact; no rounding logic is exercised for IN_WIDTH <= 24.
- No NaN, infinity or denormal is ever produced. Max exponent is 127 + 31 + 1 = 159.

## Timing
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: one sample per cycle.
- Stall control:
  - All stages advance together on adv = out_ready || !out_valid.
  - in_ready = adv && resetn. in_ready is combinational from out_ready and out_valid.
- Bubbles are not collapsed; a stalled pipeline freezes every stage.
- Holding rules:
  - While out_valid && !out_ready, float_out and out_valid hold stable.
  - No sample is dropped or duplicated.
- Reset:
  - While resetn = 0: all stage valid bits clear, out_valid = 0, float_out = 0, in_ready = 0.
  - Reset mid-stream discards all in-flight samples.
  - First acceptance is possible on the first cycle with resetn = 1.
- Simultaneous output and input transfer in one cycle is legal; both complete.

## Configuration
- INT_TO_FLOAT_RNE_EN:
  - Defined: round-to-nearest, ties-to-even.
  - Round up if guard && (sticky || frac[0]).
- Undefined:
  - Truncate toward zero; guard/sticky ignored.
  - The increment and exponent-carry logic is removed.
- Scope: affects only magnitudes with p > 23; identical results otherwise.

## Test plan
- Signed values, IN_WIDTH=16, SIGNED=1, out_ready=1:
  - 1 -> 0x3F800000.
  - -1 -> 0xBF800000.
  - -32768 -> 0xC7000000.
  - 0 -> 0x00000000.
  - Each result arrives 3 cycles after acceptance.
- Unsigned value, IN_WIDTH=16, SIGNED=0:
  - 0xFFFF -> 0x477FFF00.
  - 0x8000 -> 0x47000000.
- Rounding, IN_WIDTH=32, SIGNED=1, INT_TO_FLOAT_RNE_EN defined:
  - 16777217 -> 0x4B800000 (tie, round down to even).
  - 16777219 -> 0x4B800002 (tie, round up).
  - 33554431 -> 0x4C000000 (mantissa carry into exponent).
- Truncation, same inputs with the macro undefined:
  - 16777217 -> 0x4B800000.
  - 16777219 -> 0x4B800001.
  - 33554431 -> 0x4BFFFFFF.
- Backpressure:
  - Stimulus: stream 10 back-to-back samples; toggle out_ready with a pseudo-random pattern.
  - Required: output order and values match the reference model exactly.
  - Required: float_out stable while stalled.
  - Required: in_ready = 0 only when out_valid && !out_ready.
- Reset mid-stream:
  - Stimulus: assert resetn = 0 for 1 cycle with 3 samples in flight.
  - Required: out_valid = 0 and float_out = 0 the next cycle.
  - Required: none of the 3 samples ever appears.
  - Required: a new sample accepted after release emerges 3 cycles later.
